// File: rtl/traffic_light_monitor_if.sv
// Light buses from the intersection controller. The controller drives
// them through the master modport; the monitor observes them as slave.
interface traffic_light_monitor_if;
    logic [2:0] light_NORTH;
    logic [2:0] light_EAST;
    logic [2:0] light_WEST;
    logic [2:0] light_SOUTH;

    modport master (
        output light_NORTH,
        output light_EAST,
        output light_WEST,
        output light_SOUTH
    );

    modport slave (
        input light_NORTH,
        input light_EAST,
        input light_WEST,
        input light_SOUTH
    );
endinterface

// File: rtl/traffic_light_monitor.sv
// Passive phase-protocol checker for a four-approach intersection.
// Decodes the light buses into a phase, checks encoding, conflicts,
// phase order and dwell limits, and counts completed P3->P0 rotations.
module traffic_light_monitor #(
    parameter int unsigned MIN_DWELL = 1,
    parameter int unsigned MAX_DWELL = 16,
    parameter int unsigned DW        = 8,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clr_err,
    traffic_light_monitor_if.slave  lights,
    output logic [1:0]              phase,
    output logic                    phase_valid,
    output logic [DW-1:0]           dwell,
    output logic [4:0]              err_flags,
    output logic                    err_pulse,
    output logic [CNT_W-1:0]        cycles
);

    localparam logic [2:0]       Red      = 3'b100;
    localparam logic [2:0]       Yellow   = 3'b010;
    localparam logic [2:0]       Green    = 3'b001;
    localparam logic [DW-1:0]    DwellOne = DW'(1);
    localparam logic [DW-1:0]    DwellMax = '1;
    localparam logic [DW-1:0]    MinDw    = DW'(MIN_DWELL);
    localparam logic [DW-1:0]    MaxDw    = DW'(MAX_DWELL);
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

    typedef enum logic {StInit, StTrack} state_e;
    state_e state_q;

    logic       enc, conflict, phase_bad, legal;
    logic [1:0] sample_phase;
    logic [1:0] next_phase;
    logic [4:0] err_det;

    function automatic logic code_ok(input logic [2:0] c);
        return (c == Red) || (c == Yellow) || (c == Green);
    endfunction

    // Classify the current sample: encoding, conflict, phase pattern.
    always_comb begin
        enc          = !(code_ok(lights.light_NORTH) && code_ok(lights.light_EAST) &&
                         code_ok(lights.light_WEST) && code_ok(lights.light_SOUTH));
        conflict     = !enc &&
                       ((lights.light_NORTH != Red) || (lights.light_EAST != Red)) &&
                       ((lights.light_WEST != Red) || (lights.light_SOUTH != Red));
        legal        = 1'b0;
        sample_phase = 2'd0;
        if (lights.light_WEST == Red && lights.light_SOUTH == Red) begin
            if (lights.light_NORTH == Green && lights.light_EAST == Green) begin
                legal        = 1'b1;
                sample_phase = 2'd0;
            end else if (lights.light_NORTH == Yellow && lights.light_EAST == Yellow) begin
                legal        = 1'b1;
                sample_phase = 2'd1;
            end
        end
        if (lights.light_NORTH == Red && lights.light_EAST == Red) begin
            if (lights.light_WEST == Green && lights.light_SOUTH == Green) begin
                legal        = 1'b1;
                sample_phase = 2'd2;
            end else if (lights.light_WEST == Yellow && lights.light_SOUTH == Yellow) begin
                legal        = 1'b1;
                sample_phase = 2'd3;
            end
        end
        phase_bad = !enc && !conflict && !legal;
    end

    // Errors detected on this sample, including sequence and dwell checks.
    always_comb begin
        next_phase = phase + 2'd1;
        err_det    = {2'b00, phase_bad, conflict, enc};
        if (legal && state_q == StTrack) begin
            if (sample_phase == phase) begin
                // Fires once, on the sample that takes dwell to MAX_DWELL+1.
                if (dwell == MaxDw) err_det[4] = 1'b1;
            end else begin
                if (sample_phase != next_phase) err_det[3] = 1'b1;
                if (dwell < MinDw)              err_det[4] = 1'b1;
            end
        end
    end

    // Tracking state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StInit;
            phase       <= 2'd0;
            phase_valid <= 1'b0;
            dwell       <= '0;
            err_flags   <= '0;
            err_pulse   <= 1'b0;
            cycles      <= '0;
        end else begin
            err_flags <= (clr_err ? 5'b00000 : err_flags) | err_det;
            err_pulse <= |err_det;
            if (!legal) begin
                state_q     <= StInit;
                phase_valid <= 1'b0;
                dwell       <= '0;
            end else if (state_q == StInit) begin
                state_q     <= StTrack;
                phase_valid <= 1'b1;
                phase       <= sample_phase;
                dwell       <= DwellOne;
            end else if (sample_phase == phase) begin
                if (dwell != DwellMax) dwell <= dwell + DwellOne;
            end else begin
                // P3->P0 is always in sequence, so no separate SEQ test needed.
                if (phase == 2'd3 && sample_phase == 2'd0) cycles <= cycles + CntOne;
                phase <= sample_phase;
                dwell <= DwellOne;
            end
        end
    end

endmodule
